// File: rtl/serpent_cipher_ctrl.sv
// Serpent block-cipher controller: owns the expanded-key memory, sequences key schedule and round engine.
// Optional decrypt support (reversed subkey order) is enabled by defining SERPENT_CTRL_DECRYPT_EN.
module serpent_cipher_ctrl #(
   parameter int unsigned KEY_W  = 256,
   parameter int unsigned BLK_W  = 128,
   parameter int unsigned NUM_SK = 33,
   parameter int unsigned AW     = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_key_valid,
   input  logic [KEY_W-1:0] i_key,
   output logic             o_key_ready,
   output logic             o_key_loaded,
   input  logic             i_in_valid,
   input  logic [BLK_W-1:0] i_in_data,
   input  logic             i_in_decrypt,
   output logic             o_in_ready,
   output logic             o_out_valid,
   output logic [BLK_W-1:0] o_out_data,
   input  logic             i_out_ready,
   output logic             o_ks_start,
   output logic [KEY_W-1:0] o_ks_key,
   input  logic             i_ks_we,
   input  logic [AW-1:0]    i_ks_addr,
   input  logic [BLK_W-1:0] i_ks_subkey,
   output logic             o_eng_start,
   output logic [BLK_W-1:0] o_eng_data,
   output logic             o_eng_decrypt,
   input  logic             i_eng_rd,
   input  logic [AW-1:0]    i_eng_idx,
   output logic [BLK_W-1:0] o_eng_subkey,
   input  logic             i_eng_done,
   input  logic [BLK_W-1:0] i_eng_data,
   output logic             o_busy
);

   localparam int unsigned CW = $clog2(NUM_SK + 1);
   localparam logic [AW:0] SK_LIM = (AW+1)'(NUM_SK);

   typedef enum logic [2:0] {S_IDLE, S_KSCHED, S_READY, S_CRYPT, S_OUT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_key_acc;
   logic             w_blk_acc;
   logic             w_wr_acc;
   logic             w_loaded_set;
   logic             w_done;
   logic             w_out_acc;
   logic [CW-1:0]    r_wr_cnt;
   logic [CW-1:0]    w_wr_cnt_inc;
   logic [BLK_W-1:0] r_mem [NUM_SK];
   logic [AW-1:0]    w_rd_addr;
   logic [BLK_W-1:0] w_rd_data;

   logic             r_key_loaded;
   logic             r_ks_start;
   logic [KEY_W-1:0] r_ks_key;
   logic             r_eng_start;
   logic [BLK_W-1:0] r_eng_data;
   logic [BLK_W-1:0] r_eng_subkey;
   logic             r_out_valid;
   logic [BLK_W-1:0] r_out_data;
   logic             r_busy;

   // Only in-range writes during key scheduling land in memory and count
   assign w_wr_acc     = (r_state == S_KSCHED) && i_ks_we && ({1'b0, i_ks_addr} < SK_LIM);
   assign w_wr_cnt_inc = r_wr_cnt + CW'(1);

`ifdef SERPENT_CTRL_DECRYPT_EN
   logic r_eng_decrypt;

   always_ff @(posedge i_clk) begin
      if (i_rst)          r_eng_decrypt <= 1'b0;
      else if (w_blk_acc) r_eng_decrypt <= i_in_decrypt;
   end

   // Decrypt walks the subkeys in reverse; wrap in AW bits pushes bad indices out of range
   assign w_rd_addr     = r_eng_decrypt ? (AW'(NUM_SK - 1) - i_eng_idx) : i_eng_idx;
   assign o_eng_decrypt = r_eng_decrypt;
`else
   logic w_unused_decrypt;

   assign w_unused_decrypt = i_in_decrypt;
   assign w_rd_addr        = i_eng_idx;
   assign o_eng_decrypt    = 1'b0;
`endif

   assign w_rd_data = ({1'b0, w_rd_addr} < SK_LIM) ? r_mem[w_rd_addr] : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_key_ready  = 1'b0;
      o_in_ready   = 1'b0;
      w_key_acc    = 1'b0;
      w_blk_acc    = 1'b0;
      w_loaded_set = 1'b0;
      w_done       = 1'b0;
      w_out_acc    = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_key_ready = 1'b1;
            if (i_key_valid) begin
               w_key_acc   = 1'b1;
               w_state_nxt = S_KSCHED;
            end
         end
         S_KSCHED: begin
            if (w_wr_acc && (w_wr_cnt_inc == CW'(NUM_SK))) begin
               w_loaded_set = 1'b1;
               w_state_nxt  = S_READY;
            end
         end
         S_READY: begin
            o_key_ready = 1'b1;
            o_in_ready  = ~i_key_valid;
            if (i_key_valid) begin
               w_key_acc   = 1'b1;
               w_state_nxt = S_KSCHED;
            end else if (i_in_valid) begin
               w_blk_acc   = 1'b1;
               w_state_nxt = S_CRYPT;
            end
         end
         S_CRYPT: begin
            if (i_eng_done) begin
               w_done      = 1'b1;
               w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            if (i_out_ready) begin
               w_out_acc   = 1'b1;
               w_state_nxt = S_READY;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_key_loaded <= 1'b0;
         r_ks_start   <= 1'b0;
         r_ks_key     <= '0;
         r_eng_start  <= 1'b0;
         r_eng_data   <= '0;
         r_eng_subkey <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_busy       <= 1'b0;
         r_wr_cnt     <= '0;
      end else begin
         r_ks_start  <= w_key_acc;
         r_eng_start <= w_blk_acc;
         r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_READY);
         if (w_key_acc) begin
            r_ks_key     <= i_key;
            r_key_loaded <= 1'b0;
            r_wr_cnt     <= '0;
         end else if (w_wr_acc) begin
            r_wr_cnt <= w_wr_cnt_inc;
         end
         if (w_loaded_set) r_key_loaded <= 1'b1;
         if (w_blk_acc) r_eng_data <= i_in_data;
         if ((r_state == S_CRYPT) && i_eng_rd) r_eng_subkey <= w_rd_data;
         if (w_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_eng_data;
         end else if (w_out_acc) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Subkey storage is deliberately left unreset
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) r_mem[i_ks_addr] <= i_ks_subkey;
   end

   assign o_key_loaded = r_key_loaded;
   assign o_ks_start   = r_ks_start;
   assign o_ks_key     = r_ks_key;
   assign o_eng_start  = r_eng_start;
   assign o_eng_data   = r_eng_data;
   assign o_eng_subkey = r_eng_subkey;
   assign o_out_valid  = r_out_valid;
   assign o_out_data   = r_out_data;
   assign o_busy       = r_busy;

endmodule
